// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder slice.
// Holds the legal operand-width range and a helper that the top uses
// to reject illegal WIDTH values while the design is elaborated.
package full_adder_pkg;

  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 64;

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/full_adder_if.sv
// Signal bundle for a full_adder instance.
// The driver of the operands uses the master modport; the adder side uses
// the slave modport. clk/reset are not part of the bundle.
//   a, b   operands              (master -> slave)
//   cIn    carry-in to bit 0     (master -> slave)
//   s      combinational sum     (slave -> master)
//   cOut   combinational carry   (slave -> master)
//   s_q    registered sum        (slave -> master)
//   cout_q registered carry      (slave -> master)
interface full_adder_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cIn;
  logic [WIDTH-1:0] s;
  logic             cOut;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  modport master (
    output a, b, cIn,
    input  s, cOut, s_q, cout_q
  );

  modport slave (
    input  a, b, cIn,
    output s, cOut, s_q, cout_q
  );

endinterface

// File: rtl/full_adder_cell.sv
// One-bit full adder cell.
//   a, b  operand bits
//   ci    carry in
//   s     sum bit      = a ^ b ^ ci
//   co    carry out    = majority(a, b, ci)
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry full adder, WIDTH bits (default 1 = classic adder cell).
//   a, b    in   WIDTH  operands
//   cIn     in   1      carry into bit 0
//   s       out  WIDTH  combinational sum, zero latency
//   cOut    out  1      combinational carry out of the MSB
//   clk     in   1      rising-edge clock for s_q/cout_q only
//   reset   in   1      asynchronous active-high clear of s_q/cout_q
//   s_q     out  WIDTH  s registered on posedge clk
//   cout_q  out  1      cOut registered on posedge clk
// The first five ports are kept in front so the short positional form
// (a, b, cIn, s, cOut) still works with the clock/reset left open; the
// combinational path never depends on clk or reset.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cIn,
  output logic [WIDTH-1:0] s,
  output logic             cOut,
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q
);

  if (!width_ok(WIDTH)) begin : g_width_check
    $error("full_adder: WIDTH=%0d outside legal range %0d..%0d",
           WIDTH, MIN_WIDTH, MAX_WIDTH);
  end

  // c[i] is the carry into bit i; c[WIDTH] is the final carry out.
  logic [WIDTH:0] c;

  assign c[0] = cIn;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cOut = c[WIDTH];

  // Output register stage: one-cycle copy of the combinational result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s;
      cout_q <= cOut;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: a WIDTH=1 and a WIDTH=8 instance,
// directed vector tables, hand-written register/reset sequences and a
// random WIDTH=8 sweep checked against plain integer addition.
module tb_full_adder;

  logic clk;
  logic reset;

  int checks;
  int errors;

  full_adder_if #(.WIDTH(1)) if1 ();
  full_adder_if #(.WIDTH(8)) if8 ();

  full_adder #(.WIDTH(1)) dut1 (
    .a      (if1.a),
    .b      (if1.b),
    .cIn    (if1.cIn),
    .s      (if1.s),
    .cOut   (if1.cOut),
    .clk    (clk),
    .reset  (reset),
    .s_q    (if1.s_q),
    .cout_q (if1.cout_q)
  );

  full_adder #(.WIDTH(8)) dut8 (
    .a      (if8.a),
    .b      (if8.b),
    .cIn    (if8.cIn),
    .s      (if8.s),
    .cOut   (if8.cOut),
    .clk    (clk),
    .reset  (reset),
    .s_q    (if8.s_q),
    .cout_q (if8.cout_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic a;
    logic b;
    logic ci;
    logic s;
    logic co;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec8_t;

  vec1_t tab1 [8];
  vec8_t tab8 [8];

  logic [7:0] ra;
  logic [7:0] rb;
  logic       rc;
  logic [8:0] exp9;

  initial begin
    checks = 0;
    errors = 0;

    tab1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tab1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tab1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tab1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tab1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tab1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tab1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tab1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    tab8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    tab8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tab8[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tab8[3] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tab8[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tab8[5] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
    tab8[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    tab8[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    reset   = 1'b0;
    if1.a   = 1'b0; if1.b = 1'b0; if1.cIn = 1'b0;
    if8.a   = 8'h00; if8.b = 8'h00; if8.cIn = 1'b0;

    // Asynchronous clear: reset rises before the first clock edge.
    #1 reset = 1'b1;
    #1;
    chk("rst_s_q_w1",    64'(if1.s_q),    64'd0);
    chk("rst_cout_q_w1", 64'(if1.cout_q), 64'd0);
    chk("rst_s_q_w8",    64'(if8.s_q),    64'd0);
    chk("rst_cout_q_w8", 64'(if8.cout_q), 64'd0);

    // Sequence with 1 time unit between steps, reset still held.
    if1.a = 1'b0; if1.b = 1'b0; if1.cIn = 1'b0; #1;
    chk("seq0", {if1.cOut, if1.s}, 2'b00);
    if1.a = 1'b0; if1.b = 1'b1; if1.cIn = 1'b0; #1;
    chk("seq1", {if1.cOut, if1.s}, 2'b01);
    if1.a = 1'b0; if1.b = 1'b1; if1.cIn = 1'b1; #1;
    chk("seq2", {if1.cOut, if1.s}, 2'b10);
    if1.a = 1'b1; if1.b = 1'b1; if1.cIn = 1'b1; #1;
    chk("seq3", {if1.cOut, if1.s}, 2'b11);

    for (int i = 0; i < 8; i++) begin
      if1.a = tab1[i].a; if1.b = tab1[i].b; if1.cIn = tab1[i].ci;
      #1;
      chk($sformatf("w1_vec%0d", i), {if1.cOut, if1.s}, {tab1[i].co, tab1[i].s});
    end

    for (int i = 0; i < 8; i++) begin
      if8.a = tab8[i].a; if8.b = tab8[i].b; if8.cIn = tab8[i].ci;
      #1;
      chk($sformatf("w8_vec%0d", i), {if8.cOut, if8.s}, {tab8[i].co, tab8[i].s});
    end

    // Registers must stay clear across clock edges while reset is high.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_s_q",    64'(if1.s_q),    64'd0);
    chk("rst_hold_cout_q", 64'(if1.cout_q), 64'd0);

    // Release reset, 1+1+0 loads s_q=0, cout_q=1 on the first edge.
    @(negedge clk);
    reset = 1'b0;
    if1.a = 1'b1; if1.b = 1'b1; if1.cIn = 1'b0;
    @(posedge clk); #1;
    chk("reg_first_s_q",    64'(if1.s_q),    64'd0);
    chk("reg_first_cout_q", 64'(if1.cout_q), 64'd1);

    // Load s_q=1, then assert reset between edges.
    @(negedge clk);
    if1.a = 1'b1; if1.b = 1'b0; if1.cIn = 1'b0;
    @(posedge clk); #1;
    chk("reg_load_s_q", 64'(if1.s_q), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_s_q",    64'(if1.s_q),    64'd0);
    chk("midrst_cout_q", 64'(if1.cout_q), 64'd0);
    chk("midrst_s_comb", {if1.cOut, if1.s}, 2'b01);

    @(negedge clk);
    reset = 1'b0;

    // Random WIDTH=8 sweep.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      if8.a = ra; if8.b = rb; if8.cIn = rc;
      exp9 = 9'(ra) + 9'(rb) + 9'(rc);
      #1;
      chk("rnd_comb", {if8.cOut, if8.s}, exp9);
      @(posedge clk); #1;
      chk("rnd_reg", {if8.cout_q, if8.s_q}, exp9);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
